// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] IMEM_TOP = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            adel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry registered queue between fetch and decode; head is a register.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t tail;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == CNT_W'(0)) head <= push_data;
          else                    tail <= push_data;
          count <= count + CNT_W'(1);
        end
        2'b01: begin
          head  <= tail;
          count <= count - CNT_W'(1);
        end
        2'b11: begin
          if (count == CNT_W'(1)) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: fetch PC, single-outstanding imem reads,
// redirect handling and a 2-entry queue toward decode.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_adel,
  input  logic            id_ready
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;
  logic            pc_legal;
  logic            slot_free;
  logic            push, pop, flush;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic [CNT_W-1:0] count;

  assign pc_legal  = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= RESET_PC) && (fetch_pc <= IMEM_TOP);
  // Issue only happens from RUN, where nothing is outstanding, so count alone reserves the slot.
  assign slot_free = count < CNT_W'(DEPTH);
  assign pop       = if_valid & id_ready & ~redirect;
  assign imem_addr = fetch_pc;

  assign if_valid = (count != CNT_W'(0));
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign if_adel  = head.adel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      pend_pc  <= pend_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pend_pc_n  = pend_pc;
    imem_req   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    push_data  = '0;
    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_n = redirect_pc;
      // An outstanding read becomes stale unless its data lands this same cycle.
      case (state)
        WAIT, DROP: state_n = imem_rvalid ? RUN : DROP;
        default:    state_n = RUN;
      endcase
    end else begin
      case (state)
        RUN: begin
          if (slot_free) begin
            if (pc_legal) begin
              imem_req   = 1'b1;
              pend_pc_n  = fetch_pc;
              fetch_pc_n = fetch_pc + 32'd4;
              state_n    = WAIT;
            end else begin
              push      = 1'b1;
              push_data = '{pc: fetch_pc, instr: 32'h0, adel: 1'b1};
              state_n   = HALT;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push      = 1'b1;
            push_data = '{pc: pend_pc, instr: imem_rdata, adel: 1'b0};
            state_n   = RUN;
          end
        end
        DROP: begin
          if (imem_rvalid) state_n = RUN;
        end
        HALT: ;
        default: state_n = RUN;
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

endmodule
